testport_checker: RTL
=====================

Name: testport_checker

Overview:
- Parametrised, synthesisable self-check monitor on the CPU data-memory write bus.
- Detects a begin-symbol write to a dedicated test port, then compares each later test-port write against a loadable answer RAM, counts mismatches and cycles, and raises finish/pass.
- Successor to the fixed 3-entry ROM checker: configurable check count, width and answer depth, runtime answer loading, timeout, and saturating counters.
- Sits beside the processor at top level; the bench only watches its outputs.

Parameters:
- ADDR_W, 30, word-address width of addr.
- DATA_W, 32, data width.
- TEST_PORT, 30'hFF, word address of the test port.
- BEGIN_SYMBOL, 32'h00000168, data value that starts checking.
- CHECK_NUM, 3, number of checked writes (1..ANS_DEPTH).
- ANS_DEPTH, 16, answer RAM entries; IDX_W = clog2(ANS_DEPTH+1).
- ERR_W, 8, error counter width.
- DUR_W, 16, duration counter width.
- TIMEOUT, 16'hFFFF, CHECK cycles before forced report; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- addr  in  ADDR_W  memory write word address
- data  in  DATA_W  memory write data
- wen  in  1  memory write enable (may stay high across D-cache stalls)
- ans_we  in  1  answer RAM write strobe
- ans_addr  in  IDX_W  answer RAM index
- ans_data  in  DATA_W  answer value
- error_num  out  ERR_W  mismatch count
- duration  out  DUR_W  cycles spent in CHECK
- finish  out  1  high in REPORT
- pass  out  1  finish && error_num==0 && !timeout
- timeout  out  1  report was forced by timeout
- first_err_idx  out  IDX_W  index of first mismatch (optional feature)
- first_err_data  out  DATA_W  data of first mismatch (optional feature)

Behaviour:
- Reset (rst=0, async): state IDLE, idx=0, error_num all-ones, duration=0, timeout=0, filter ARMED, first_err_* = 0. Answer RAM contents are not reset.
- Write qualifier (sub-FSM, active in all states):
  - ARMED: wen=1 -> HELD, and this cycle is a qualified write.
  - HELD: wen=0 -> ARMED.
  - A wen held N cycles counts once; back-to-back writes need one wen-low cycle between them.
- Test write = qualified write && addr==TEST_PORT.
- IDLE:
  - ans_we writes ans_data to RAM[ans_addr]. Writes with ans_addr >= ANS_DEPTH are ignored.
  - Test write with data==BEGIN_SYMBOL -> CHECK next cycle, error_num=0, duration=0, idx=0.
  - The begin write itself is never compared.
  - Other test writes are ignored.
- CHECK:
  - duration increments every cycle, saturating at all-ones.
  - On a test write: compare data with RAM[idx] combinationally; on mismatch error_num+1, saturating at all-ones. Then idx+1.
  - ans_we is ignored.
  - Registered idx==CHECK_NUM -> REPORT next cycle. Latency: last check write, +1 cycle idx update, +1 cycle finish.
  - Timeout: TIMEOUT!=0 and duration==TIMEOUT-1 -> REPORT with timeout=1. If the final check write lands in the same cycle, it is still counted; timeout=1 still wins.
- REPORT: all outputs frozen, finish=1, all inputs ignored until reset.
- Reset asserted mid-CHECK: immediate return to IDLE with reset values; RAM keeps its answers, so a rerun needs no reload.
- Non-test-port writes never affect counters.

Optional Feature:
- Macro CHECKER_FIRST_ERR_EN.
- Defined: on the first mismatch in CHECK, capture idx into first_err_idx and data into first_err_data. Hold until reset; later mismatches do not overwrite.
- Undefined: capture registers are not generated; first_err_idx and first_err_data are tied to 0.

Decomposition:
- Shared package testport_pkg:
  - state encoding ST_IDLE=2'b00, ST_CHECK=2'b01, ST_REPORT=2'b10;
  - default TEST_PORT and BEGIN_SYMBOL constants;
  - saturating-increment function.
- One sub-module, wen_edge_filter: the ARMED/HELD qualifier, output qual_wen.
- Answer RAM is inline register array.

Test Plan:
- Load RAM[0..2]={1,1,32'hD5D}, CHECK_NUM=3; begin write, then writes 1,1,0xD5D each with wen low between -> finish=1, error_num=0, pass=1, timeout=0.
- Same load; writes 1,7,0xD5D -> error_num=1, pass=0; with CHECKER_FIRST_ERR_EN, first_err_idx=1, first_err_data=7.
- Begin, then wen held high 5 cycles on one test write of 1, then writes 1,0xD5D -> exactly 3 compares, error_num=0.
- TIMEOUT=20; begin, then one check write only -> at duration=19 state goes REPORT, timeout=1, finish=1, pass=0.
- Pulse rst low mid-CHECK after 1 write -> error_num=8'hFF, duration=0, finish=0 immediately; re-run without reload -> passes.
- ERR_W=2, CHECK_NUM=5, all five writes mismatching -> error_num saturates at 3; a test write with non-begin data in IDLE is ignored.

Source files
------------

// File: rtl/testport_pkg.sv
// Shared definitions for the test-port checker: FSM encodings, default
// port/begin constants and a saturating increment helper.
package testport_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CHECK  = 2'b01,
        ST_REPORT = 2'b10
    } state_t;

    typedef enum logic {
        FLT_ARMED = 1'b0,
        FLT_HELD  = 1'b1
    } filt_t;

    localparam logic [29:0] DEF_TEST_PORT    = 30'hFF;
    localparam logic [31:0] DEF_BEGIN_SYMBOL = 32'h0000_0168;

    // Callers zero-extend narrower counters to 32 bits and pass their all-ones value as limit.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/wen_edge_filter.sv
// Turns a write enable that may stay high across cache stalls into a
// single-cycle qualified write; a new write needs one wen-low cycle first.
module wen_edge_filter
    import testport_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wen,
    output logic qual_wen
);

    filt_t state;
    filt_t state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FLT_ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FLT_ARMED: if (wen)  state_nxt = FLT_HELD;
            FLT_HELD:  if (!wen) state_nxt = FLT_ARMED;
            default:   state_nxt = FLT_ARMED;
        endcase
    end

    assign qual_wen = (state == FLT_ARMED) && wen;

endmodule

// File: rtl/testport_checker.sv
// Self-check monitor on the data-memory write bus: after a begin symbol it
// compares test-port writes against a loadable answer RAM. Optional macro: CHECKER_FIRST_ERR_EN.
module testport_checker
    import testport_pkg::*;
#(
    parameter int                ADDR_W       = 30,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT    = ADDR_W'(DEF_TEST_PORT),
    parameter logic [DATA_W-1:0] BEGIN_SYMBOL = DATA_W'(DEF_BEGIN_SYMBOL),
    parameter int                CHECK_NUM    = 3,
    parameter int                ANS_DEPTH    = 16,
    parameter int                ERR_W        = 8,
    parameter int                DUR_W        = 16,
    parameter logic [DUR_W-1:0]  TIMEOUT      = DUR_W'(16'hFFFF),
    localparam int               IDX_W        = $clog2(ANS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              ans_we,
    input  logic [IDX_W-1:0]  ans_addr,
    input  logic [DATA_W-1:0] ans_data,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int               RAM_AW    = (ANS_DEPTH > 1) ? $clog2(ANS_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHECK_NUM);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(ANS_DEPTH);
    localparam logic [DUR_W-1:0] TO_LAST   = TIMEOUT - DUR_W'(1);
    localparam logic [31:0]      ERR_MAX   = 32'({ERR_W{1'b1}});
    localparam logic [31:0]      DUR_MAX   = 32'({DUR_W{1'b1}});

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] ram [ANS_DEPTH];
    logic              qual_wen;
    logic              test_wr;
    logic              begin_hit;
    logic              check_wr;
    logic              mismatch;
    logic              timeout_hit;

    wen_edge_filter u_filter (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .qual_wen (qual_wen)
    );

    assign test_wr     = qual_wen && (addr == TEST_PORT);
    assign begin_hit   = (state == ST_IDLE) && test_wr && (data == BEGIN_SYMBOL);
    // Writes after the last checked one must not index past the RAM.
    assign check_wr    = (state == ST_CHECK) && test_wr && (idx < LAST_IDX);
    assign mismatch    = check_wr && (data != ram[idx[RAM_AW-1:0]]);
    assign timeout_hit = (TIMEOUT != '0) && (duration == TO_LAST);

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && ans_we && ans_addr < DEPTH_IDX) begin
            ram[ans_addr[RAM_AW-1:0]] <= ans_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (begin_hit) state_nxt = ST_CHECK;
            ST_CHECK: if (idx == LAST_IDX || timeout_hit) state_nxt = ST_REPORT;
            default:  state_nxt = state;
        endcase
    end

    always_comb begin
        finish = (state == ST_REPORT);
        pass   = finish && (error_num == '0) && !timeout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            error_num <= '1;
            duration  <= '0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (begin_hit) begin
                        idx       <= '0;
                        error_num <= '0;
                        duration  <= '0;
                    end
                end
                ST_CHECK: begin
                    duration <= DUR_W'(sat_inc(32'(duration), DUR_MAX));
                    if (check_wr) idx <= idx + IDX_W'(1);
                    if (mismatch) error_num <= ERR_W'(sat_inc(32'(error_num), ERR_MAX));
                    if (timeout_hit) timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CHECKER_FIRST_ERR_EN
    logic              first_seen;
    logic [IDX_W-1:0]  first_idx;
    logic [DATA_W-1:0] first_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_seen <= 1'b0;
            first_idx  <= '0;
            first_data <= '0;
        end else if (mismatch && !first_seen) begin
            first_seen <= 1'b1;
            first_idx  <= idx;
            first_data <= data;
        end
    end

    assign first_err_idx  = first_idx;
    assign first_err_data = first_data;
`else
    assign first_err_idx  = '0;
    assign first_err_data = '0;
`endif

endmodule
